// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream through a 2-entry skid buffer; optional beat counter via FIFO_STREAM_READER_STATS_EN.
// Latency: FIFO non-empty with idle buffer -> fifo_rd_en same cycle -> m_valid two cycles later; one beat per cycle sustained.
// Backpressure: reads are only issued when buffer slots plus in-flight reads leave room, so m_ready=0 stalls after two reads.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [15:0]           beat_count
);

  localparam logic [2:0] BUF_SLOTS = 3'(BUF_DEPTH);

  logic [1:0]            occ;
  logic                  inflight;
  logic                  head;
  logic                  tail;
  logic [DATA_WIDTH-1:0] buf_mem [0:1];

  logic       pop;
  logic       push;
  logic [2:0] committed;

  assign pop  = m_valid && m_ready;
  assign push = inflight && !flush;

  // Slots already claimed after this cycle's pop; m_ready feeds straight into the read decision.
  assign committed  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = !rst && !flush && !fifo_empty && (committed < BUF_SLOTS);

  assign m_valid = (occ != 2'd0);
  assign m_data  = m_valid ? buf_mem[head] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= occ + {1'b0, push} - {1'b0, pop};
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && push) buf_mem[tail] <= fifo_rd_data;
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [15:0] beat_q;

  always_ff @(posedge clk) begin
    if (rst)
      beat_q <= 16'h0000;
    else if (pop && !flush)
      beat_q <= beat_q + 16'd1;
  end

  assign beat_count = beat_q;
`else
  assign beat_count = 16'h0000;
`endif

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side master for the team's synchronous FIFO. It drains the FIFO through its wr_en/rd_en/full/empty interface and presents the data as a valid/ready stream. It never issues a read while the FIFO reports empty, which keeps the FIFO's no-read-when-empty rule satisfied by construction. A 2-entry output buffer absorbs the 1-cycle FIFO read latency and sustains one beat per cycle under continuous m_ready.

Parameters:
DATA_WIDTH, 8, width of the FIFO data and of the stream data.
BUF_DEPTH, 2, output buffer entries; fixed at 2, other values unsupported.

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous reset, active-high
flush  input  1  synchronous drop of buffered and in-flight data
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  FIFO read strobe
fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
m_valid  output  1  stream data valid
m_ready  input  1  stream sink ready
m_data  output  DATA_WIDTH  stream data
beat_count  output  16  accepted-beat counter (optional feature)

Behaviour:
- State registers:
  - occ: 0..2, buffer occupancy.
  - inflight: 1 bit, a read was issued last cycle.
  - head and tail pointers, 1 bit each, wrap modulo 2.
  - buf[0..1].
- Reset, while rst=1 at a posedge: occ=0, inflight=0, head=tail=0, buf contents don't-care. fifo_rd_en=0 combinationally while rst=1. m_valid=0, m_data=0, beat_count=0.
- pop = m_valid && m_ready.
- fifo_rd_en = !rst && !flush && !fifo_empty && (occ + inflight - pop) < 2.
  - Combinational path from m_ready to fifo_rd_en is intended; it gives full throughput.
  - Invariant: occ + inflight <= 2 at all times.
- inflight_next = fifo_rd_en.
- When inflight=1 and flush=0: fifo_rd_data is written to buf[tail] and tail toggles.
- m_valid = (occ != 0). m_data = buf[head] when m_valid, else 0.
- On pop, head toggles.
- occ_next = occ + (inflight && !flush) - pop.
  - Simultaneous push and pop at occ=1 or occ=2 leaves occ unchanged.
- Latency: FIFO goes non-empty at cycle t with buffer empty -> fifo_rd_en at t -> m_valid at t+2.
- Backpressure: with m_ready=0, at most 2 reads are outstanding or buffered. fifo_rd_en stays 0 until a pop.
- m_valid and m_data are held stable while m_valid=1 and m_ready=0.
- Flush, for one cycle:
  - occ, head, tail and inflight are cleared.
  - fifo_rd_en is forced 0.
  - pop is ignored for beat_count.
  - Data returning the cycle after a flush is discarded, because inflight was cleared.
- fifo_empty rising while a read is in flight is legal; the in-flight data is still captured.
- Reset has priority over flush. Reset mid-transfer discards all buffered data.

Optional Feature:
Macro FIFO_STREAM_READER_STATS_EN.
- Defined: beat_count increments by 1 on each pop and wraps from 16'hFFFF to 0. Cleared by rst, not by flush.
- Undefined: beat_count is tied to 16'h0000 and no counter logic is built. Port list is unchanged.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, fifo_empty=1, then rst=0 -> fifo_rd_en=0, m_valid=0, m_data=0, beat_count=0 on every cycle.
- Streaming: FIFO preloaded with 0x01..0x10, m_ready=1 -> fifo_rd_en high from cycle 0. m_valid high from cycle 2. 16 consecutive beats 0x01..0x10. fifo_rd_en never high while fifo_empty=1. beat_count=16 with STATS_EN.
- Backpressure: 4 entries 0xA0..0xA3, m_ready=0 -> exactly 2 fifo_rd_en pulses, then stall. m_data holds 0xA0. After m_ready=1, the sink receives 0xA0..0xA3 in order with no loss or duplication.
- Empty boundary: single entry 0x55, fifo_empty rises the cycle after the read -> one rd_en pulse, one beat 0x55, then m_valid=0.
- Flush with data in flight: buffer holds 0x11, read of 0x22 issued, flush=1 for one cycle -> m_valid=0 next cycle and 0x22 discarded. Next FIFO entry 0x33 is delivered normally.
- Counter wrap (STATS_EN): 65537 pops -> beat_count=1. Without the macro -> beat_count=0 throughout.
